// File: rtl/hazard_pkg.sv
// Shared types and control encodings for the pipeline hazard logic.
package hazard_pkg;

  localparam int REG_ADDR_W_DEFAULT = 4;

  typedef enum logic [1:0] {RUN, LOAD_STALL} hazard_state_t;

  typedef struct packed {
    logic en_pc;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and memory-wait detection, shared with the forwarding unit.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  load_use,
  output logic                  mem_stall
);

  // Register 0 is an ordinary register here; no zero-register exemption.
  assign load_use  = ex_mem_read & ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                                    (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign mem_stall = mem_req & ~mem_ready;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline enable/flush control: load-use bubbles, memory-wait freeze, branch flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEFAULT,
  parameter int LOAD_BUBBLES = 1
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  output logic                  en_pc,
  output logic                  en_if_id,
  output logic                  en_id_ex,
  output logic                  en_ex_mem,
  output logic                  en_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_ex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_BUBBLES - 1);

  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 3) begin : g_bad_bubbles
    $error("LOAD_BUBBLES must be in 1..3");
  end

  hazard_state_t state, state_next;
  logic [1:0]    bubble_cnt, cnt_next;
  logic          load_use, mem_stall;
  pipe_ctrl_t    ctrl;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .load_use    (load_use),
    .mem_stall   (mem_stall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      bubble_cnt <= '0;
    end else begin
      state      <= state_next;
      bubble_cnt <= cnt_next;
    end
  end

  // A memory wait freezes the FSM entirely, so a frozen branch is seen again on release.
  always_comb begin
    state_next = state;
    cnt_next   = bubble_cnt;
    if (!mem_stall) begin
      case (state)
        RUN: begin
          if (!branch_taken && load_use && (LOAD_BUBBLES > 1)) begin
            cnt_next   = BUBBLE_INIT;
            state_next = LOAD_STALL;
          end
        end
        LOAD_STALL: begin
          if (branch_taken) begin
            cnt_next   = '0;
            state_next = RUN;
          end else begin
            cnt_next = bubble_cnt - 2'd1;
            if (bubble_cnt == 2'd1) state_next = RUN;
          end
        end
        default: begin
          cnt_next   = '0;
          state_next = RUN;
        end
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_RUN;
    if (!reset) begin
      ctrl = CTRL_RUN;
    end else if (mem_stall) begin
      ctrl = CTRL_FREEZE;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken)  ctrl = CTRL_BRANCH;
          else if (load_use) ctrl = CTRL_BUBBLE;
        end
        LOAD_STALL: ctrl = branch_taken ? CTRL_BRANCH : CTRL_BUBBLE;
        default:    ctrl = CTRL_RUN;
      endcase
    end
  end

  assign en_pc       = ctrl.en_pc;
  assign en_if_id    = ctrl.en_if_id;
  assign en_id_ex    = ctrl.en_id_ex;
  assign en_ex_mem   = ctrl.en_ex_mem;
  assign en_mem_wb   = ctrl.en_mem_wb;
  assign flush_if_id = ctrl.flush_if_id;
  assign flush_id_ex = ctrl.flush_id_ex;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!ctrl.en_pc)                          stall_cycles <= stall_cycles + CNT_W'(1);
      if (ctrl.flush_if_id | ctrl.flush_id_ex) flush_count  <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit, run on LOAD_BUBBLES=1 and =2 instances in parallel.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, mem_req, mem_ready, branch_taken;

  logic en_pc1, en_if_id1, en_id_ex1, en_ex_mem1, en_mem_wb1, flush_if_id1, flush_id_ex1;
  logic en_pc2, en_if_id2, en_id_ex2, en_ex_mem2, en_mem_wb2, flush_if_id2, flush_id_ex2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall1, flush1, stall2, flush2;
`endif

  // {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex}
  localparam logic [6:0] RUNV = 7'b1111100;
  localparam logic [6:0] LDV  = 7'b0011101;
  localparam logic [6:0] BRV  = 7'b1111111;
  localparam logic [6:0] STV  = 7'b0000000;

  typedef struct packed {
    logic [6:0] e1;
    logic [6:0] e2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] obs1, obs2;
  assign obs1 = {en_pc1, en_if_id1, en_id_ex1, en_ex_mem1, en_mem_wb1, flush_if_id1, flush_id_ex1};
  assign obs2 = {en_pc2, en_if_id2, en_id_ex2, en_ex_mem2, en_mem_wb2, flush_if_id2, flush_id_ex2};

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(4), .LOAD_BUBBLES(1)) dut1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .en_pc(en_pc1), .en_if_id(en_if_id1), .en_id_ex(en_id_ex1), .en_ex_mem(en_ex_mem1),
    .en_mem_wb(en_mem_wb1), .flush_if_id(flush_if_id1), .flush_id_ex(flush_id_ex1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall1), .flush_count(flush1)
`endif
  );

  hazard_control_unit #(.REG_ADDR_W(4), .LOAD_BUBBLES(2)) dut2 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .en_pc(en_pc2), .en_if_id(en_if_id2), .en_id_ex(en_id_ex2), .en_ex_mem(en_ex_mem2),
    .en_mem_wb(en_mem_wb2), .flush_if_id(flush_if_id2), .flush_id_ex(flush_id_ex2)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall2), .flush_count(flush2)
`endif
  );

  // Drives one cycle of inputs and queues the outputs each instance should show for it.
  task automatic drive(input logic ld, input logic [3:0] rd, input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rs2, input logic u2, input logic mreq, input logic mrdy,
                       input logic br, input logic [6:0] e1, input logic [6:0] e2);
    exp_t x;
    ex_mem_read  = ld;
    ex_rd        = rd;
    id_rs1       = rs1;
    id_uses_rs1  = u1;
    id_rs2       = rs2;
    id_uses_rs2  = u2;
    mem_req      = mreq;
    mem_ready    = mrdy;
    branch_taken = br;
    x.e1 = e1;
    x.e2 = e2;
    sb.push_back(x);
  endtask

  task automatic idle(input logic [6:0] e1, input logic [6:0] e2);
    drive(1'b0, 4'd0, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, e1, e2);
  endtask

  task automatic test_reset();
    exp_t x;
    drive(1'b1, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, RUNV, RUNV);
    #2;
    x = sb.pop_front();
    checks += 2;
    if (obs1 !== x.e1) begin errors++; $display("FAIL reset lb1: got %b want %b", obs1, x.e1); end
    if (obs2 !== x.e2) begin errors++; $display("FAIL reset lb2: got %b want %b", obs2, x.e2); end
`ifdef HAZARD_PERF_CNT_EN
    checks += 1;
    if ({stall1, flush1, stall2, flush2} !== 128'd0) begin
      errors++; $display("FAIL reset_counters: got %h want 0", {stall1, flush1, stall2, flush2});
    end
`endif
    idle(RUNV, RUNV);
    void'(sb.pop_front());
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use_rs1();
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b1, 4'd5, 4'd5, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, LDV, LDV);
        1:       idle(RUNV, LDV);
        default: idle(RUNV, RUNV);
      endcase
      @(negedge clk);
      x = sb.pop_front();
      checks += 2;
      if (obs1 !== x.e1) begin errors++; $display("FAIL load_use_rs1 step %0d lb1: got %b want %b", i, obs1, x.e1); end
      if (obs2 !== x.e2) begin errors++; $display("FAIL load_use_rs1 step %0d lb2: got %b want %b", i, obs2, x.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use_rs2();
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b1, 4'd0, 4'd7, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, LDV, LDV);
        1:       idle(RUNV, LDV);
        2:       drive(1'b1, 4'd3, 4'd3, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, RUNV, RUNV);
        default: drive(1'b0, 4'd5, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, RUNV, RUNV);
      endcase
      @(negedge clk);
      x = sb.pop_front();
      checks += 2;
      if (obs1 !== x.e1) begin errors++; $display("FAIL load_use_rs2 step %0d lb1: got %b want %b", i, obs1, x.e1); end
      if (obs2 !== x.e2) begin errors++; $display("FAIL load_use_rs2 step %0d lb2: got %b want %b", i, obs2, x.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_in_stall();
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b1, 4'd5, 4'd5, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, LDV, LDV);
        1:       drive(1'b0, 4'd0, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, BRV, BRV);
        default: idle(RUNV, RUNV);
      endcase
      @(negedge clk);
      x = sb.pop_front();
      checks += 2;
      if (obs1 !== x.e1) begin errors++; $display("FAIL branch_in_stall step %0d lb1: got %b want %b", i, obs1, x.e1); end
      if (obs2 !== x.e2) begin errors++; $display("FAIL branch_in_stall step %0d lb2: got %b want %b", i, obs2, x.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    exp_t x;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] s1, s2, f1;
    s1 = stall1; s2 = stall2; f1 = flush1;
`endif
    for (int i = 0; i < 5; i++) begin
      case (i)
        0, 1, 2: drive(1'b0, 4'd0, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, STV, STV);
        3:       drive(1'b0, 4'd0, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, RUNV, RUNV);
        default: idle(RUNV, RUNV);
      endcase
      @(negedge clk);
      x = sb.pop_front();
      checks += 2;
      if (obs1 !== x.e1) begin errors++; $display("FAIL mem_wait step %0d lb1: got %b want %b", i, obs1, x.e1); end
      if (obs2 !== x.e2) begin errors++; $display("FAIL mem_wait step %0d lb2: got %b want %b", i, obs2, x.e2); end
      @(posedge clk); #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    checks += 3;
    if (stall1 - s1 !== 32'd3) begin errors++; $display("FAIL mem_wait_stall_cycles lb1: got %0d want 3", stall1 - s1); end
    if (stall2 - s2 !== 32'd3) begin errors++; $display("FAIL mem_wait_stall_cycles lb2: got %0d want 3", stall2 - s2); end
    if (flush1 - f1 !== 32'd0) begin errors++; $display("FAIL mem_wait_flush_count: got %0d want 0", flush1 - f1); end
`endif
  endtask

  task automatic test_branch_mem_wait();
    exp_t x;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] s1, f1, f2;
    s1 = stall1; f1 = flush1; f2 = flush2;
`endif
    for (int i = 0; i < 4; i++) begin
      case (i)
        0, 1:    drive(1'b0, 4'd0, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, STV, STV);
        2:       drive(1'b0, 4'd0, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, BRV, BRV);
        default: idle(RUNV, RUNV);
      endcase
      @(negedge clk);
      x = sb.pop_front();
      checks += 2;
      if (obs1 !== x.e1) begin errors++; $display("FAIL branch_mem_wait step %0d lb1: got %b want %b", i, obs1, x.e1); end
      if (obs2 !== x.e2) begin errors++; $display("FAIL branch_mem_wait step %0d lb2: got %b want %b", i, obs2, x.e2); end
      @(posedge clk); #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    checks += 3;
    if (flush1 - f1 !== 32'd1) begin errors++; $display("FAIL branch_mem_wait_flush_count lb1: got %0d want 1", flush1 - f1); end
    if (flush2 - f2 !== 32'd1) begin errors++; $display("FAIL branch_mem_wait_flush_count lb2: got %0d want 1", flush2 - f2); end
    if (stall1 - s1 !== 32'd2) begin errors++; $display("FAIL branch_mem_wait_stall_cycles: got %0d want 2", stall1 - s1); end
`endif
  endtask

  task automatic test_branch_and_load();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      case (i)
        0:       drive(1'b1, 4'd6, 4'd6, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, BRV, BRV);
        default: idle(RUNV, RUNV);
      endcase
      @(negedge clk);
      x = sb.pop_front();
      checks += 2;
      if (obs1 !== x.e1) begin errors++; $display("FAIL branch_and_load step %0d lb1: got %b want %b", i, obs1, x.e1); end
      if (obs2 !== x.e2) begin errors++; $display("FAIL branch_and_load step %0d lb2: got %b want %b", i, obs2, x.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b1, 4'd5, 4'd5, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, LDV, LDV);
        1:       drive(1'b0, 4'd0, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, STV, STV);
        2:       drive(1'b0, 4'd0, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, RUNV, LDV);
        default: idle(RUNV, RUNV);
      endcase
      @(negedge clk);
      x = sb.pop_front();
      checks += 2;
      if (obs1 !== x.e1) begin errors++; $display("FAIL back_to_back step %0d lb1: got %b want %b", i, obs1, x.e1); end
      if (obs2 !== x.e2) begin errors++; $display("FAIL back_to_back step %0d lb2: got %b want %b", i, obs2, x.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t x;
    drive(1'b1, 4'd5, 4'd5, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, LDV, LDV);
    @(negedge clk);
    x = sb.pop_front();
    checks += 2;
    if (obs1 !== x.e1) begin errors++; $display("FAIL reset_mid_stall enter lb1: got %b want %b", obs1, x.e1); end
    if (obs2 !== x.e2) begin errors++; $display("FAIL reset_mid_stall enter lb2: got %b want %b", obs2, x.e2); end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(RUNV, RUNV);
    #1;
    x = sb.pop_front();
    checks += 2;
    if (obs1 !== x.e1) begin errors++; $display("FAIL reset_mid_stall held lb1: got %b want %b", obs1, x.e1); end
    if (obs2 !== x.e2) begin errors++; $display("FAIL reset_mid_stall held lb2: got %b want %b", obs2, x.e2); end
`ifdef HAZARD_PERF_CNT_EN
    checks += 1;
    if ({stall2, flush2} !== 64'd0) begin errors++; $display("FAIL reset_mid_stall_counters: got %h want 0", {stall2, flush2}); end
`endif
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    idle(RUNV, RUNV);
    @(negedge clk);
    x = sb.pop_front();
    checks += 2;
    if (obs1 !== x.e1) begin errors++; $display("FAIL reset_mid_stall after lb1: got %b want %b", obs1, x.e1); end
    if (obs2 !== x.e2) begin errors++; $display("FAIL reset_mid_stall after lb2: got %b want %b", obs2, x.e2); end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use_rs1();
    test_load_use_rs2();
    test_branch_in_stall();
    test_mem_wait();
    test_branch_mem_wait();
    test_branch_and_load();
    test_back_to_back();
    test_reset_mid_stall();
    checks += 1;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
